// File: rtl/graycounter_param.sv
// graycounter_param: modulo-DEPTH Gray-code counter with up/down, load, wrap pulse and optional self-check (GRAYCNT_CHECK_EN)
module graycounter_param #(
   parameter int WIDTH   = 5,
   parameter int DEPTH   = 8,
   parameter int RST_IDX = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_idx,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             wrap,
   output logic             load_err,
   output logic             chk_err
);
   localparam int OFFSET = ((1 << WIDTH) - DEPTH) / 2;
   localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);
   localparam logic [WIDTH-1:0] LAST  = WIDTH'(DEPTH - 1);
   localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_IDX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   if (WIDTH < 2 || WIDTH > 16 || DEPTH < 2 || DEPTH % 2 != 0 || DEPTH > (1 << WIDTH) ||
       RST_IDX < 0 || RST_IDX >= DEPTH) begin : g_bad_params
      $error("graycounter_param: illegal WIDTH/DEPTH/RST_IDX");
   end

   // The index window is centred on 2^(WIDTH-1) so the wrap step is also a single-bit change
   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] idx);
      logic [WIDTH-1:0] x;
      x = idx + OFF_W;
      return x ^ (x >> 1);
   endfunction

   logic [WIDTH-1:0] nxt_bin, nxt_gray;
   logic             nxt_wrap, nxt_lerr;

   // Next index by priority load > enable > hold, modulo DEPTH, then Gray-encode before registering
   always_comb begin
      nxt_bin  = bin_out;
      nxt_wrap = 1'b0;
      nxt_lerr = 1'b0;
      if (load) begin
         nxt_lerr = load_idx > LAST;
         nxt_bin  = nxt_lerr ? bin_out : load_idx;
      end else if (enable) begin
         nxt_wrap = dir ? (bin_out == '0) : (bin_out == LAST);
         nxt_bin  = nxt_wrap ? (dir ? LAST : '0) : (dir ? bin_out - ONE : bin_out + ONE);
      end
      nxt_gray = to_gray(nxt_bin);
   end

   // State and pulse registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_out  <= RST_W;
         gray_out <= to_gray(RST_W);
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         bin_out  <= nxt_bin;
         gray_out <= nxt_gray;
         wrap     <= nxt_wrap;
         load_err <= nxt_lerr;
      end
   end

`ifdef GRAYCNT_CHECK_EN
   logic [WIDTH-1:0] prev_gray, diff;
   logic             step_q;
   assign diff = gray_out ^ prev_gray;

   // Sticky monitor: a counting step must flip exactly one bit, and the code must always match the index
   always_ff @(posedge clk) begin
      if (reset) begin
         chk_err   <= 1'b0;
         step_q    <= 1'b0;
         prev_gray <= '0;
      end else begin
         step_q    <= enable & ~load;
         prev_gray <= gray_out;
         if ((step_q && (diff == '0 || (diff & (diff - ONE)) != '0)) || gray_out != to_gray(bin_out))
            chk_err <= 1'b1;
      end
   end
`else
   assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_graycounter_param.sv
// tb_graycounter_param: scoreboard bench for graycounter_param (WIDTH=3/DEPTH=6 main instance, default-parameter instance for the 8-state ring)
module tb_graycounter_param;
   localparam int W   = 3;
   localparam int D   = 6;
   localparam int R   = 0;
   localparam int OFF = (2 ** W - D) / 2;

   typedef struct {
      int bin;
      int gray;
      bit wrap;
      bit lerr;
      bit chk;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1, enable = 1'b0, dir = 1'b0, load = 1'b0;
   logic [W-1:0] load_idx = '0;
   logic [W-1:0] gray_out, bin_out;
   logic         wrap, load_err, chk_err;

   logic         reset8 = 1'b1, en8 = 1'b0, zero8 = 1'b0;
   logic [4:0]   idx8 = '0;
   logic [4:0]   gray8, bin8;
   logic         wrap8, lerr8, chk8;

   graycounter_param #(.WIDTH(W), .DEPTH(D), .RST_IDX(R)) dut (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load), .load_idx(load_idx),
      .gray_out(gray_out), .bin_out(bin_out), .wrap(wrap), .load_err(load_err), .chk_err(chk_err)
   );

   graycounter_param dut8 (
      .clk(clk), .reset(reset8), .enable(en8), .dir(zero8), .load(zero8), .load_idx(idx8),
      .gray_out(gray8), .bin_out(bin8), .wrap(wrap8), .load_err(lerr8), .chk_err(chk8)
   );

   exp_t q[$];
   exp_t mx;
   int   m_idx = R;
   int   total = 0, passed = 0;

   function automatic int g(int x);
      return x ^ (x >> 1);
   endfunction

   task automatic check(string n, int act, int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: actual %0d required %0d", n, act, req);
   endtask

   // Drive one cycle of stimulus and push the reference model's expected outputs
   task automatic step(bit r, bit e, bit d, bit l, int li);
      exp_t x;
      @(negedge clk);
      reset = r; enable = e; dir = d; load = l; load_idx = W'(li);
      x.wrap = 0; x.lerr = 0; x.chk = 0;
      if (r) m_idx = R;
      else if (l) begin
         if (li < D) m_idx = li;
         else x.lerr = 1;
      end else if (e) begin
         if (!d) begin x.wrap = (m_idx == D - 1); m_idx = (m_idx + 1) % D; end
         else begin x.wrap = (m_idx == 0); m_idx = (m_idx + D - 1) % D; end
      end
      x.bin  = m_idx;
      x.gray = g(m_idx + OFF);
      q.push_back(x);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 10) begin @(negedge clk); n++; end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
   endtask

   // Monitor: outputs are present every cycle, compare against the oldest expectation
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         mx = q.pop_front();
         check("bin_out",  int'(bin_out),  mx.bin);
         check("gray_out", int'(gray_out), mx.gray);
         check("wrap",     int'(wrap),     int'(mx.wrap));
         check("load_err", int'(load_err), int'(mx.lerr));
         check("chk_err",  int'(chk_err),  int'(mx.chk));
      end
   end

   initial begin
      logic [4:0] prev8;
      logic [W-1:0] gf;
      // Default 8-state ring: every step flips exactly one bit, including the wrap
      @(negedge clk); reset8 = 1'b1;
      @(negedge clk); reset8 = 1'b0;
      check("d8_reset_gray", int'(gray8), g(0 + 12));
      prev8 = gray8;
      en8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("d8_onebit", $countones(gray8 ^ prev8), 1);
         check("d8_gray", int'(gray8), g((i + 1) % 8 + 12));
         if (i == 6) check("d8_idx7_gray", int'(gray8), 5'b11010);
         if (i == 7) check("d8_wrap", int'(wrap8), 1);
         prev8 = gray8;
      end
      en8 = 1'b0;
      // Main instance directed plan
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 5);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 3);
      step(0, 0, 0, 1, 7);
      step(0, 1, 1, 1, 6);
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      // Randomised traffic with occasional mid-count reset and out-of-range loads
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < 15, $urandom_range(0, 7));
      step(0, 0, 0, 0, 0);
      drain();
`ifdef GRAYCNT_CHECK_EN
      gf = gray_out ^ 3'b011;
      force dut.gray_out = gf;
      repeat (3) @(negedge clk);
      check("chk_set", int'(chk_err), 1);
      release dut.gray_out;
      repeat (3) @(negedge clk);
      check("chk_sticky", int'(chk_err), 1);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      drain();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
